drive_seq_ctrl: RTL

DRIVE_SEQ_CTRL -- requirements
Module: drive_seq_ctrl

---
 rtl/drive_seq_ctrl_if.sv | 28 ++
 rtl/drive_seq_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/drive_seq_ctrl_if.sv
// Sequencer-to-datapath bundle: start/abort control, drive_pc load path,
// instruction fetch data and the play request/ready handshake.
interface drive_seq_ctrl_if #(
    parameter int PC_WIDTH = 11
);
    logic                start;
    logic [PC_WIDTH-1:0] start_addr;
    logic                abort;
    logic [PC_WIDTH-1:0] PC;
    logic [15:0]         inst_rdata;
    logic                play_ready;
    logic                update_pc;
    logic [PC_WIDTH-1:0] next_PC;
    logic                play_valid;
    logic [7:0]          play_idx;
    logic                busy;
    logic                done;

    modport master (
        input  start, start_addr, abort, PC, inst_rdata, play_ready,
        output update_pc, next_PC, play_valid, play_idx, busy, done
    );

    modport slave (
        output start, start_addr, abort, PC, inst_rdata, play_ready,
        input  update_pc, next_PC, play_valid, play_idx, busy, done
    );
endinterface

// File: rtl/drive_seq_ctrl.sv
// Pulse-drive sequencer: fetches 16-bit instructions and issues PC loads and play requests.
// Outputs are combinational from state/inputs; a PLAY stalls in EXEC until play_ready.
module drive_seq_ctrl #(
    parameter int PC_WIDTH   = 11,
    parameter int LOOP_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    drive_seq_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WAIT} state_t;

    localparam logic [2:0] OP_PLAY     = 3'b001;
    localparam logic [2:0] OP_WAIT     = 3'b010;
    localparam logic [2:0] OP_JUMP     = 3'b011;
    localparam logic [2:0] OP_LOOP_SET = 3'b100;
    localparam logic [2:0] OP_LOOP_BR  = 3'b101;
    localparam logic [2:0] OP_HALT     = 3'b111;

    state_t                state, state_nxt;
    logic [10:0]           wait_cnt, wait_nxt;
    logic [LOOP_WIDTH-1:0] loop_cnt, loop_nxt;
    logic [2:0]            opcode;
    logic [10:0]           operand;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   target;
    logic                  advance;
    logic                  unused_inst;

    assign opcode       = bus.inst_rdata[15:13];
    assign operand      = bus.inst_rdata[10:0];
    assign unused_inst  = ^bus.inst_rdata[12:11];
    assign pc_inc       = bus.PC + PC_WIDTH'(1);
    assign target       = PC_WIDTH'(operand);
    assign bus.play_idx = bus.inst_rdata[7:0];
    assign bus.busy     = !rst && (state != IDLE);

    always_comb begin
        bus.update_pc  = 1'b0;
        bus.next_PC    = bus.PC;
        bus.play_valid = 1'b0;
        bus.done       = 1'b0;
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        loop_nxt       = loop_cnt;
        advance        = 1'b0;

        // Abort outranks everything the current instruction would do.
        if (!rst && state != IDLE && bus.abort) begin
            state_nxt = IDLE;
        end else if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.update_pc = 1'b1;
                        bus.next_PC   = bus.start_addr;
                        state_nxt     = FETCH;
                    end
                end
                FETCH: state_nxt = EXEC;
                EXEC: begin
                    case (opcode)
                        OP_PLAY: begin
                            bus.play_valid = 1'b1;
                            advance        = bus.play_ready;
                        end
                        OP_WAIT: begin
                            if (operand == 11'd0) begin
                                advance = 1'b1;
                            end else begin
                                wait_nxt  = operand;
                                state_nxt = WAIT;
                            end
                        end
                        OP_JUMP: begin
                            bus.update_pc = 1'b1;
                            bus.next_PC   = target;
                            state_nxt     = FETCH;
                        end
                        OP_LOOP_SET: begin
                            loop_nxt = LOOP_WIDTH'(operand);
                            advance  = 1'b1;
                        end
                        OP_LOOP_BR: begin
                            if (loop_cnt != '0) begin
                                loop_nxt      = loop_cnt - LOOP_WIDTH'(1);
                                bus.update_pc = 1'b1;
                                bus.next_PC   = target;
                                state_nxt     = FETCH;
                            end else begin
                                advance = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            bus.done  = 1'b1;
                            state_nxt = IDLE;
                        end
                        default: advance = 1'b1;
                    endcase
                end
                WAIT: begin
                    if (wait_cnt <= 11'd1) begin
                        advance = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt - 11'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (advance) begin
                bus.update_pc = 1'b1;
                bus.next_PC   = pc_inc;
                state_nxt     = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            loop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            loop_cnt <= loop_nxt;
        end
    end
endmodule
